// File: rtl/hero_sprite_sequencer_pkg.sv
// Shared types and constants for the hero sprite sequencer.
package hero_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_JUMP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    JUMP = ST_JUMP
  } hero_state_t;

  typedef enum logic {
    FACE_RIGHT = 1'b0,
    FACE_LEFT  = 1'b1
  } facing_t;

  localparam logic [2:0] ROM_IDLE = 3'd5;
  localparam logic [2:0] ROM_JUMP = 3'd6;

endpackage

// File: rtl/hero_sprite_sequencer_if.sv
// Control and pixel-fetch bus of the hero sprite sequencer.
// HERO_BLINK_EN adds the invuln input.
interface hero_sprite_sequencer_if #(
  parameter int unsigned ADDR_W = 11
);
  logic              frame_start;
  logic              move_left;
  logic              move_right;
  logic              jump;
  logic              on_ground;
  logic [9:0]        hero_x;
  logic [9:0]        hero_y;
  logic [9:0]        draw_x;
  logic [9:0]        draw_y;
  logic [ADDR_W-1:0] rom_addr;
  logic [2:0]        rom_sel;
  logic [2:0]        rom_index;
  logic [2:0]        pal_index;
  logic              pix_opaque;
`ifdef HERO_BLINK_EN
  logic              invuln;

  modport master (
    output frame_start, move_left, move_right, jump, on_ground,
           hero_x, hero_y, draw_x, draw_y, rom_index, invuln,
    input  rom_addr, rom_sel, pal_index, pix_opaque
  );
  modport slave (
    input  frame_start, move_left, move_right, jump, on_ground,
           hero_x, hero_y, draw_x, draw_y, rom_index, invuln,
    output rom_addr, rom_sel, pal_index, pix_opaque
  );
`else
  modport master (
    output frame_start, move_left, move_right, jump, on_ground,
           hero_x, hero_y, draw_x, draw_y, rom_index,
    input  rom_addr, rom_sel, pal_index, pix_opaque
  );
  modport slave (
    input  frame_start, move_left, move_right, jump, on_ground,
           hero_x, hero_y, draw_x, draw_y, rom_index,
    output rom_addr, rom_sel, pal_index, pix_opaque
  );
`endif
endinterface

// File: rtl/hero_sprite_sequencer_anim_timer.sv
// Run-cycle timer: hold counter and run frame index, advanced once per tick.
module hero_anim_timer #(
  parameter int unsigned NUM_RUN    = 5,
  parameter int unsigned FRAME_HOLD = 6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       tick,
  input  logic       clear,
  input  logic       enable,
  output logic [2:0] frame
);
  localparam int unsigned HW = $clog2(FRAME_HOLD + 1);

  logic [HW-1:0] hold_q, hold_d;
  logic [2:0]    frame_q, frame_d;

  always_comb begin
    hold_d  = hold_q;
    frame_d = frame_q;
    if (clear) begin
      hold_d  = '0;
      frame_d = '0;
    end else if (tick && enable) begin
      if (hold_q == HW'(FRAME_HOLD - 1)) begin
        hold_d  = '0;
        frame_d = (frame_q == 3'(NUM_RUN - 1)) ? '0 : frame_q + 3'd1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hold_q  <= '0;
      frame_q <= '0;
    end else begin
      hold_q  <= hold_d;
      frame_q <= frame_d;
    end
  end

  assign frame = frame_q;

endmodule

// File: rtl/hero_sprite_sequencer.sv
// Hero animation state machine plus 2-stage sprite pixel fetch pipeline.
// Optional HERO_BLINK_EN: invuln blinking of the opaque flag.
module hero_sprite_sequencer
  import hero_pkg::*;
#(
  parameter int unsigned SPRITE_W   = 32,
  parameter int unsigned SPRITE_H   = 48,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned NUM_RUN    = 5,
  parameter int unsigned FRAME_HOLD = 6,
  parameter int unsigned JUMP_MIN   = 8
) (
  input logic                    Clk,
  input logic                    Reset,
  hero_sprite_sequencer_if.slave bus
);
  localparam int unsigned JW = $clog2(JUMP_MIN + 1);

  hero_state_t       state_q, state_d;
  facing_t           facing_q, facing_d;
  logic [JW-1:0]     jump_cnt_q, jump_cnt_d;
  logic [2:0]        run_frame;
  logic              run_clear;

  logic              dir_left, dir_right, dir_any;
  assign dir_left  = bus.move_left & ~bus.move_right;
  assign dir_right = bus.move_right & ~bus.move_left;
  assign dir_any   = dir_left | dir_right;

  always_comb begin
    state_d    = state_q;
    facing_d   = facing_q;
    jump_cnt_d = jump_cnt_q;
    if (bus.frame_start) begin
      if (dir_any) facing_d = dir_left ? FACE_LEFT : FACE_RIGHT;
      if (bus.jump && bus.on_ground && state_q != JUMP) begin
        state_d    = JUMP;
        jump_cnt_d = '0;
      end else begin
        case (state_q)
          JUMP: begin
            if (jump_cnt_q >= JW'(JUMP_MIN - 1) && bus.on_ground)
              state_d = dir_any ? RUN : IDLE;
            else if (jump_cnt_q != '1)
              jump_cnt_d = jump_cnt_q + 1'b1;
          end
          IDLE:    if (dir_any) state_d = RUN;
          RUN:     if (!dir_any) state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign run_clear = bus.frame_start && state_d == RUN && state_q != RUN;

  hero_anim_timer #(
    .NUM_RUN   (NUM_RUN),
    .FRAME_HOLD(FRAME_HOLD)
  ) u_anim_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .tick  (bus.frame_start),
    .clear (run_clear),
    .enable(state_q == RUN),
    .frame (run_frame)
  );

  // rom_sel derives only from registers that move on frame_start.
  always_comb begin
    case (state_q)
      RUN:     bus.rom_sel = run_frame;
      JUMP:    bus.rom_sel = ROM_JUMP;
      default: bus.rom_sel = ROM_IDLE;
    endcase
  end

  logic [9:0]        col, row, mcol;
  logic              inbox_d, inbox_q;
  logic [31:0]       addr_full;
  logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
  logic [2:0]        pal_index_d, pal_index_q;
  logic              pix_opaque_d, pix_opaque_q;
  logic              blink_off;

  always_comb begin
    col        = bus.draw_x - bus.hero_x;
    row        = bus.draw_y - bus.hero_y;
    inbox_d    = (32'(col) < SPRITE_W) && (32'(row) < SPRITE_H);
    mcol       = (facing_q == FACE_LEFT) ? 10'(SPRITE_W - 1) - col : col;
    addr_full  = 32'(row) * SPRITE_W + 32'(mcol);
    rom_addr_d = inbox_d ? addr_full[ADDR_W-1:0] : '0;
  end

`ifdef HERO_BLINK_EN
  logic [2:0] blink_q, blink_d;
  always_comb begin
    blink_d = bus.frame_start ? blink_q + 3'd1 : blink_q;
  end
  always_ff @(posedge Clk) begin
    if (Reset) blink_q <= '0;
    else       blink_q <= blink_d;
  end
  assign blink_off = bus.invuln & blink_q[2];
`else
  assign blink_off = 1'b0;
`endif

  always_comb begin
    pal_index_d  = inbox_q ? bus.rom_index : '0;
    pix_opaque_d = inbox_q && (bus.rom_index != '0) && !blink_off;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      facing_q     <= FACE_RIGHT;
      jump_cnt_q   <= '0;
      inbox_q      <= 1'b0;
      rom_addr_q   <= '0;
      pal_index_q  <= '0;
      pix_opaque_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      facing_q     <= facing_d;
      jump_cnt_q   <= jump_cnt_d;
      inbox_q      <= inbox_d;
      rom_addr_q   <= rom_addr_d;
      pal_index_q  <= pal_index_d;
      pix_opaque_q <= pix_opaque_d;
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.pal_index  = pal_index_q;
  assign bus.pix_opaque = pix_opaque_q;

endmodule
